// File: rtl/noc_traffic_scheduler.sv
// rtl/noc_traffic_scheduler.sv - round-robin synthetic traffic injector and delivery checker for the mesh NoC
// Injects one packet per enabled node in strict order, counts deliveries, and flags drain timeout or over-delivery.
module noc_traffic_scheduler #(
  parameter int NODES   = 16,
  parameter int ADDR_W  = $clog2(NODES),
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096,
  parameter int HB_W    = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_stride,
  input  logic [CNT_W-1:0]  i_rounds,
  input  logic [NODES-1:0]  i_ready,
  input  logic [NODES-1:0]  i_rx_val,
  output logic [NODES-1:0]  o_data_val,
  output logic [ADDR_W-1:0] o_src,
  output logic [ADDR_W-1:0] o_dest,
  output logic [CNT_W-1:0]  o_seq,
  output logic [CNT_W-1:0]  o_sent,
  output logic [CNT_W-1:0]  o_rcvd,
  output logic              o_busy,
  output logic [3:0]        led
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int PC_W = $clog2(NODES + 1);
  localparam logic [ADDR_W:0] LP_NODES = (ADDR_W + 1)'(NODES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INJECT,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic [ADDR_W-1:0]   r_stride;
  logic [CNT_W-1:0]    r_rounds;
  logic [CNT_W-1:0]    r_round;
  logic [CNT_W-1:0]    w_round_nxt;
  logic [CNT_W-1:0]    w_round_inc;
  logic [WD_W-1:0]     r_wdog;
  logic [WD_W-1:0]     w_wdog_nxt;
  logic [HB_W-1:0]     r_hb;
  logic                r_done;
  logic                r_err;
  logic [CNT_W-1:0]    w_sent_nxt;
  logic [CNT_W-1:0]    w_rcvd_nxt;
  logic [CNT_W-1:0]    w_rcvd_sat;
  logic [CNT_W:0]      w_rcvd_sum;
  logic [PC_W-1:0]     w_rx_cnt;
  logic [ADDR_W:0]     w_dest_sum;
  logic [ADDR_W-1:0]   w_dest;
  logic [NODES-1:0]    w_onehot;
  logic                w_last;
  logic                w_inject;
  logic                w_start;

  always_comb begin
    w_rx_cnt = '0;
    for (int k = 0; k < NODES; k++) begin
      w_rx_cnt = w_rx_cnt + PC_W'(i_rx_val[k]);
    end
  end

  // Delivery count saturates rather than wrapping so over-delivery can never alias to a match.
  assign w_rcvd_sum  = {1'b0, o_rcvd} + (CNT_W + 1)'(w_rx_cnt);
  assign w_rcvd_sat  = w_rcvd_sum[CNT_W] ? {CNT_W{1'b1}} : w_rcvd_sum[CNT_W-1:0];

  // One extra bit keeps the sum exact so the single conditional subtract works for any NODES.
  assign w_dest_sum  = {1'b0, r_ptr} + {1'b0, r_stride};
  assign w_dest      = (w_dest_sum >= LP_NODES) ? ADDR_W'(w_dest_sum - LP_NODES) : ADDR_W'(w_dest_sum);

  assign w_onehot    = {{(NODES - 1){1'b0}}, 1'b1} << r_ptr;
  assign w_last      = (r_ptr == ADDR_W'(NODES - 1));
  assign w_round_inc = r_round + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_round_nxt = r_round;
    w_wdog_nxt  = r_wdog;
    w_sent_nxt  = o_sent;
    w_rcvd_nxt  = o_rcvd;
    w_inject    = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_clear && i_start) begin
          w_start     = 1'b1;
          w_ptr_nxt   = '0;
          w_round_nxt = '0;
          w_wdog_nxt  = '0;
          w_sent_nxt  = '0;
          w_rcvd_nxt  = '0;
          w_state_nxt = (i_rounds == '0) ? S_DRAIN : S_INJECT;
        end
      end
      S_INJECT: begin
        w_rcvd_nxt = w_rcvd_sat;
        if (i_ready[r_ptr]) begin
          w_inject   = 1'b1;
          w_sent_nxt = o_sent + CNT_W'(1);
          if (w_last) begin
            w_ptr_nxt   = '0;
            w_round_nxt = w_round_inc;
            if (w_round_inc == r_rounds) begin
              w_state_nxt = S_DRAIN;
            end
          end else begin
            w_ptr_nxt = r_ptr + ADDR_W'(1);
          end
        end
        if (w_rcvd_nxt > w_sent_nxt) begin
          w_state_nxt = S_ERROR;
        end
      end
      S_DRAIN: begin
        w_rcvd_nxt = w_rcvd_sat;
        if (w_rcvd_nxt > o_sent) begin
          w_state_nxt = S_ERROR;
        end else if (o_rcvd == o_sent) begin
          w_state_nxt = S_DONE;
        end else if (|i_rx_val) begin
          w_wdog_nxt = '0;
        end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_wdog_nxt = r_wdog + WD_W'(1);
        end
      end
      S_DONE, S_ERROR: begin
        if (i_clear) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_stride   <= '0;
      r_rounds   <= '0;
      r_round    <= '0;
      r_wdog     <= '0;
      r_hb       <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      o_data_val <= '0;
      o_src      <= '0;
      o_dest     <= '0;
      o_seq      <= '0;
      o_sent     <= '0;
      o_rcvd     <= '0;
      o_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_round    <= w_round_nxt;
      r_wdog     <= w_wdog_nxt;
      r_hb       <= r_hb + HB_W'(1);
      o_sent     <= w_sent_nxt;
      o_rcvd     <= w_rcvd_nxt;
      o_data_val <= w_inject ? w_onehot : '0;
      if (w_start) begin
        r_stride <= (i_stride == '0) ? ADDR_W'(1) : i_stride;
        r_rounds <= i_rounds;
      end
      if (w_inject) begin
        o_src  <= r_ptr;
        o_dest <= w_dest;
        o_seq  <= o_sent;
      end
      // Status flags track the next state so the LEDs are plain flops.
      o_busy <= (w_state_nxt == S_INJECT) || (w_state_nxt == S_DRAIN);
      r_done <= (w_state_nxt == S_DONE);
      r_err  <= (w_state_nxt == S_ERROR);
    end
  end

  assign led = {r_done, r_err, o_busy, r_hb[HB_W-1]};

endmodule

// File: tb/tb_noc_traffic_scheduler.sv
// tb/tb_noc_traffic_scheduler.sv - randomized and directed bench for noc_traffic_scheduler with an in-bench reference model
module tb_noc_traffic_scheduler;

  localparam int N   = 5;
  localparam int AW  = 3;
  localparam int CW  = 16;
  localparam int TO  = 16;
  localparam int HBW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_start;
  logic          i_clear;
  logic [AW-1:0] i_stride;
  logic [CW-1:0] i_rounds;
  logic [N-1:0]  i_ready;
  logic [N-1:0]  i_rx_val;
  logic [N-1:0]  o_data_val;
  logic [AW-1:0] o_src;
  logic [AW-1:0] o_dest;
  logic [CW-1:0] o_seq;
  logic [CW-1:0] o_sent;
  logic [CW-1:0] o_rcvd;
  logic          o_busy;
  logic [3:0]    led;

  noc_traffic_scheduler #(
    .NODES(N), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TO), .HB_W(HBW)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_clear(i_clear),
    .i_stride(i_stride), .i_rounds(i_rounds), .i_ready(i_ready), .i_rx_val(i_rx_val),
    .o_data_val(o_data_val), .o_src(o_src), .o_dest(o_dest), .o_seq(o_seq),
    .o_sent(o_sent), .o_rcvd(o_rcvd), .o_busy(o_busy), .led(led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 idle, 1 inject, 2 drain, 3 done, 4 error.
  int m_ph, m_p, m_round, m_rounds, m_stride, m_sent, m_rcvd, m_wd, m_hb;
  int m_dv, m_src, m_dest, m_seq;
  int mc, last_rx_edge, err_edge;
  bit prev_err;

  logic [N-1:0] pend [64];
  int           sc;
  int           dly;
  int           drop_seq;
  int           extra_at;
  logic [N-1:0] extra_val;
  logic [N-1:0] extra_rx;
  bit           rand_ready;
  logic         want_rstn;

  logic [N-1:0] log_dv [$];
  int           log_dest [$];
  int           log_seq [$];
  int           base;
  int           exp_d1 [5] = '{1, 2, 3, 4, 0};
  int           exp_d3 [5] = '{3, 4, 0, 1, 2};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_p = 0; m_round = 0; m_rounds = 0; m_stride = 0; m_sent = 0; m_rcvd = 0;
    m_wd = 0; m_hb = 0; m_dv = 0; m_src = 0; m_dest = 0; m_seq = 0;
  endtask

  task automatic model_step();
    int rxc;
    int nr;
    rxc  = $countones(i_rx_val);
    nr   = (m_rcvd + rxc > 65535) ? 65535 : m_rcvd + rxc;
    m_dv = 0;
    m_hb = (m_hb + 1) % (1 << HBW);
    mc++;
    if (i_rx_val != '0) last_rx_edge = mc;
    case (m_ph)
      0: if (!i_clear && i_start) begin
        m_stride = (i_stride == 0) ? 1 : int'(i_stride);
        m_rounds = int'(i_rounds);
        m_sent = 0; m_rcvd = 0; m_round = 0; m_wd = 0; m_p = 0;
        m_ph = (i_rounds == 0) ? 2 : 1;
      end
      1: begin
        if (i_ready[m_p]) begin
          m_dv   = 1 << m_p;
          m_src  = m_p;
          m_dest = (m_p + m_stride) % N;
          m_seq  = m_sent;
          m_sent = (m_sent + 1) % 65536;
          m_p    = m_p + 1;
          if (m_p == N) begin
            m_p = 0;
            m_round++;
            if (m_round == m_rounds) m_ph = 2;
          end
        end
        m_rcvd = nr;
        if (m_rcvd > m_sent) m_ph = 4;
      end
      2: begin
        if (nr > m_sent) m_ph = 4;
        else if (m_rcvd == m_sent) m_ph = 3;
        else if (rxc != 0) m_wd = 0;
        else if (m_wd == TO - 1) m_ph = 4;
        else m_wd++;
        m_rcvd = nr;
      end
      default: if (i_clear) m_ph = 0;
    endcase
  endtask

  task automatic compare_all();
    int busy;
    busy = (m_ph == 1 || m_ph == 2) ? 1 : 0;
    chk("data_val", o_data_val, m_dv);
    chk("sent", o_sent, m_sent);
    chk("rcvd", o_rcvd, m_rcvd);
    chk("busy", o_busy, busy);
    chk("led", led, {(m_ph == 3), (m_ph == 4), busy[0], m_hb[HBW-1]});
    if (m_dv != 0) begin
      chk("src", o_src, m_src);
      chk("dest", o_dest, m_dest);
      chk("seq", o_seq, m_seq);
    end
    if (o_data_val != '0) begin
      log_dv.push_back(o_data_val);
      log_dest.push_back(int'(o_dest));
      log_seq.push_back(int'(o_seq));
    end
    if (led[2] && !prev_err) err_edge = mc;
    prev_err = led[2];
  endtask

  // One clock: drive inputs on the falling edge (network loopback included), then step model and compare.
  task automatic cycle();
    @(negedge clk);
    reset_n = want_rstn;
    if (rand_ready) i_ready = N'($urandom) | N'($urandom);
    if (m_dv != 0 && m_seq != drop_seq) pend[(sc + dly - 1) % 64] |= N'(1) << m_dest;
    i_rx_val = pend[sc % 64] | extra_rx;
    pend[sc % 64] = '0;
    extra_rx = '0;
    sc++;
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int stride, input int rounds, input bit stall);
    int n;
    int stall_left;
    for (int k = 0; k < 64; k++) pend[k] = '0;
    stall_left = 5;
    if (!rand_ready) i_ready = '1;
    i_stride = AW'(stride);
    i_rounds = CW'(rounds);
    i_start  = 1'b1;
    cycle();
    i_start = 1'b0;
    n = 0;
    while ((m_ph == 1 || m_ph == 2) && n < 400) begin
      if (!rand_ready) begin
        i_ready = '1;
        if (stall && m_ph == 1 && m_p == 2 && m_round == 0 && stall_left > 0) begin
          i_ready[2] = 1'b0;
          stall_left--;
        end
      end
      if (n == extra_at) extra_rx = extra_val;
      cycle();
      n++;
    end
    chk("run_finished", led[3] | led[2], 1);
  endtask

  task automatic clear_run();
    i_clear = 1'b1;
    cycle();
    i_clear = 1'b0;
    cycle();
  endtask

  task automatic check_order(input string tag, input int count, input int d[5]);
    chk({tag, "_count"}, log_dv.size() - base, count);
    for (int i = 0; i < count; i++) begin
      chk({tag, "_onehot"}, log_dv[base + i], N'(1) << (i % N));
      chk({tag, "_dest"}, log_dest[base + i], d[i % N]);
      chk({tag, "_seq"}, log_seq[base + i], i);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL tb_timeout actual=running required=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int stride, rounds, mode;
    reset_n = 1'b0; want_rstn = 1'b0;
    i_start = 1'b0; i_clear = 1'b0; i_stride = '0; i_rounds = '0;
    i_ready = '0; i_rx_val = '0; extra_rx = '0; extra_val = '0;
    rand_ready = 1'b0; dly = 3; drop_seq = -1; extra_at = -1; sc = 0;
    mc = 0; last_rx_edge = 0; err_edge = 0; prev_err = 1'b0;
    for (int k = 0; k < 64; k++) pend[k] = '0;
    model_reset();

    repeat (3) cycle();
    chk("rst_data_val", o_data_val, 0);
    chk("rst_sent", o_sent, 0);
    chk("rst_rcvd", o_rcvd, 0);
    chk("rst_led", led, 0);
    want_rstn = 1'b1;
    repeat (2) cycle();

    // Stride 1, two rounds, loopback 3 cycles.
    base = log_dv.size();
    run(1, 2, 1'b0);
    check_order("A", 10, exp_d1);
    chk("A_sent", o_sent, 10);
    chk("A_rcvd", o_rcvd, 10);
    chk("A_led_status", led[3:1], 3'b100);
    clear_run();

    // Node 2 stalled for five cycles in the first sweep.
    base = log_dv.size();
    run(1, 2, 1'b1);
    check_order("stall", 10, exp_d1);
    chk("stall_sent", o_sent, 10);
    clear_run();

    base = log_dv.size();
    run(0, 1, 1'b0);
    check_order("stride0", 5, exp_d1);
    chk("stride0_node4_dest", log_dest[base + 4], 0);
    clear_run();

    base = log_dv.size();
    run(3, 1, 1'b0);
    check_order("stride3", 5, exp_d3);
    clear_run();

    // Last packet lost: watchdog fires 16 cycles after the final delivery.
    drop_seq = 9;
    err_edge = 0;
    run(1, 2, 1'b0);
    chk("drop_rcvd", o_rcvd, 9);
    chk("drop_err_led", led[2], 1);
    chk("drop_timeout_cycles", err_edge - last_rx_edge, 16);
    drop_seq = -1;
    clear_run();

    // Two spurious strobes on the first injection edge.
    for (int k = 0; k < 64; k++) pend[k] = '0;
    i_ready = '1; i_stride = AW'(1); i_rounds = CW'(1);
    i_start = 1'b1; cycle(); i_start = 1'b0;
    extra_rx = N'(3);
    cycle();
    chk("over_err_led", led[2], 1);
    chk("over_rcvd", o_rcvd, 2);
    chk("over_sent", o_sent, 1);
    i_clear = 1'b1; i_start = 1'b1;
    cycle();
    chk("clear_start_busy", o_busy, 0);
    chk("clear_start_status", led[3:2], 0);
    cycle();
    chk("idle_clear_prio_busy", o_busy, 0);
    i_clear = 1'b0; i_start = 1'b0;
    cycle();

    // Reset in the middle of injection.
    for (int k = 0; k < 64; k++) pend[k] = '0;
    i_ready = '1; i_stride = AW'(1); i_rounds = CW'(2);
    i_start = 1'b1; cycle(); i_start = 1'b0;
    repeat (3) cycle();
    chk("pre_reset_pulse", o_data_val, 5'b00100);
    #1;
    reset_n = 1'b0; want_rstn = 1'b0;
    #1;
    model_reset();
    chk("async_rst_data_val", o_data_val, 0);
    chk("async_rst_sent", o_sent, 0);
    compare_all();
    repeat (2) cycle();
    want_rstn = 1'b1;
    cycle();
    base = log_dv.size();
    run(1, 1, 1'b0);
    chk("restart_first_onehot", log_dv[base], 1);
    chk("restart_first_seq", log_seq[base], 0);
    chk("restart_count", log_dv.size() - base, 5);
    clear_run();

    // Randomized runs: random enables, loopback delay, drops and spurious strobes.
    rand_ready = 1'b1;
    for (int r = 0; r < 14; r++) begin
      stride   = $urandom_range(0, N - 1);
      rounds   = $urandom_range(0, 3);
      dly      = $urandom_range(1, 4);
      mode     = $urandom_range(0, 2);
      drop_seq = (mode == 1 && rounds > 0) ? $urandom_range(0, rounds * N - 1) : -1;
      extra_at = (mode == 2) ? $urandom_range(0, 25) : -1;
      extra_val = N'($urandom_range(1, 31));
      run(stride, rounds, 1'b0);
      repeat ($urandom_range(0, 3)) cycle();
      clear_run();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_traffic_scheduler.md
Name: noc_traffic_scheduler

Overview:
- Synthetic traffic controller placed between the FPGA top level and the mesh `network`.
- Sequences packet injection from every PE node in round-robin order, honouring per-node network enables.
- Counts packets delivered by the network and reports run status on the board LEDs.
- Provides a self-checking bring-up of the NoC on hardware with no host attached.

Parameters:
- NODES, 16, number of PE nodes attached to the network.
- ADDR_W, $clog2(NODES), node address width.
- CNT_W, 16, width of the sent and received packet counters.
- TIMEOUT, 4096, drain-phase watchdog in cycles.
- HB_W, 24, heartbeat divider width; LED toggle period is 2^HB_W cycles.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  level; starts a run when sampled high in IDLE.
- i_clear  in  1  returns DONE/ERROR to IDLE.
- i_stride  in  ADDR_W  destination offset: dest = (src + stride) mod NODES.
- i_rounds  in  CNT_W  number of full node sweeps per run.
- i_ready  in  NODES  per-node injection enable from the network (bit k = node k can accept).
- i_rx_val  in  NODES  per-node packet-delivered strobe from the network.
- o_data_val  out  NODES  one-hot injection valid (i_data_val of the network).
- o_src  out  ADDR_W  source field of the injected packet.
- o_dest  out  ADDR_W  destination field of the injected packet.
- o_seq  out  CNT_W  sequence number (value of the sent count before increment).
- o_sent  out  CNT_W  packets injected this run.
- o_rcvd  out  CNT_W  packets delivered this run.
- o_busy  out  1  high in INJECT or DRAIN.
- led  out  4  {done, error, busy, heartbeat}.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; every output 0; pointer p=0; all counters 0.
- Only clk and reset_n are timing inputs. All outputs are registered.
- IDLE: on i_start=1:
  - latch stride (0 is forced to 1); latch rounds;
  - clear o_sent, o_rcvd, the round count, the watchdog and p;
  - go to INJECT.
  - If i_rounds=0, go directly to DRAIN.
- INJECT, each cycle:
  - If i_ready[p]=1: next cycle o_data_val=one-hot(p), o_src=p, o_dest=(p+stride) mod NODES, o_seq=o_sent; o_sent increments; p advances.
  - Otherwise o_data_val=0 and p holds. No skipping; strict order.
  - Latency from i_ready sample to o_data_val is 1 cycle. o_data_val is a single-cycle pulse.
  - The network guarantees acceptance when its enable was high the preceding cycle, so no retry is needed.
- Wrap: when p=NODES-1 is injected, p goes to 0 and the round count increments. When the round count reaches rounds, go to DRAIN on the same edge.
- Mod arithmetic: sum computed in ADDR_W+1 bits, subtract NODES if ≥NODES. Correct for non-power-of-2 NODES.
- Receive: every cycle in INJECT or DRAIN, o_rcvd += popcount(i_rx_val), saturating at 2^CNT_W-1. Strobes are ignored in IDLE, DONE and ERROR.
- DRAIN:
  - If o_rcvd == o_sent, go to DONE.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1, go to ERROR.
  - The watchdog resets to 0 on any cycle with a nonzero i_rx_val.
- Over-delivery: if o_rcvd > o_sent at any time, go to ERROR immediately.
- DONE/ERROR: hold counters. Return to IDLE on i_clear=1. i_start is ignored there.
- Simultaneous events:
  - i_clear has priority over i_start.
  - A final injection and a delivery in the same cycle are both counted.
- o_busy=1 in INJECT or DRAIN.
- LEDs: led[3]=DONE, led[2]=ERROR, led[1]=o_busy, led[0]=MSB of a free-running HB_W counter (cleared only by reset).
- Mid-run reset: all outputs clear asynchronously, with no partial pulse.

Test Plan:
- NODES=4, stride=1, rounds=2, i_ready all 1, loopback i_rx_val 3 cycles after injection:
  - 8 one-hot pulses 0001,0010,0100,1000,…; o_dest sequence 1,2,3,0,1,2,3,0; o_seq 0..7;
  - DONE with o_sent=o_rcvd=8; led=1000 plus heartbeat.
- i_ready[2] held 0 for 5 cycles during round 1 → injection stalls at node 2 (no node-3 pulse); resumes in order; final o_sent=8.
- stride=0 → treated as 1 (o_dest of node 3 = 0). stride=3, NODES=5 → dests 3,4,0,1,2.
- One packet never delivered, TIMEOUT=16 → ERROR 16 cycles after the last delivery; led[2]=1; o_rcvd=7.
- Extra spurious i_rx_val → ERROR in the cycle o_rcvd exceeds o_sent. i_clear and i_start high together → IDLE.
- reset_n asserted mid-INJECT → o_data_val=0 immediately. After release, a new i_start restarts from node 0 with o_seq=0.
